// File: rtl/bcd_pkg.sv
// Shared types and helpers for the serial packed-BCD adder/subtractor.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_state_e;

  function automatic logic is_bcd(input bcd_digit_t d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One decimal digit of addition: binary sum of two digits plus carry, then +6 correction.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t digit,
  output logic       cout
);

  logic [4:0] sum_s;
  logic [4:0] adj_s;

  // Binary digit sum with decimal overflow correction
  always_comb begin
    sum_s = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    adj_s = sum_s + 5'd6;
    digit = 4'd0;
    cout  = 1'b0;
    if (sum_s > 5'd9) begin
      digit = adj_s[3:0];
      cout  = 1'b1;
    end else begin
      digit = sum_s[3:0];
      cout  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// NDIG-digit packed-BCD adder/subtractor, one digit per clock, least significant digit first.
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int NDIG = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*NDIG-1:0]     a_bcd,
  input  logic [4*NDIG-1:0]     b_bcd,
  input  logic                  sub,
  input  logic                  load,
  input  logic                  start,
  output logic                  busy,
  output logic                  ready,
  output logic [4*(NDIG+1)-1:0] sum_bcd,
  output logic                  neg,
  output logic                  err
);

  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  bcd_state_e            state_r;
  logic [CW-1:0]         cnt_r;
  logic [4*NDIG-1:0]     a_op_r;
  logic [4*NDIG-1:0]     b_op_r;
  logic                  sub_op_r;
  logic [4*NDIG-1:0]     a_sh_r;
  logic [4*NDIG-1:0]     b_sh_r;
  logic                  carry_r;
  logic [4*(NDIG+1)-1:0] sum_r;
  logic                  busy_r;
  logic                  ready_r;
  logic                  neg_r;
  logic                  err_r;

  logic                  bad_digit_s;
  bcd_digit_t            b_in_s;
  bcd_digit_t            digit_s;
  logic                  cout_s;

  // Flag any non-decimal digit in the held operands
  always_comb begin
    bad_digit_s = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      bad_digit_s = bad_digit_s | ~is_bcd(a_op_r[4*i +: 4]) | ~is_bcd(b_op_r[4*i +: 4]);
    end
  end

  // Subtraction adds the nines' complement of B with an initial carry of one
  assign b_in_s = sub_op_r ? (4'd9 - b_sh_r[3:0]) : b_sh_r[3:0];

  bcd_digit_add u_digit_add (
    .a     (a_sh_r[3:0]),
    .b     (b_in_s),
    .cin   (carry_r),
    .digit (digit_s),
    .cout  (cout_s)
  );

  // Control FSM, operand capture and digit-serial datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      a_op_r   <= '0;
      b_op_r   <= '0;
      sub_op_r <= 1'b0;
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      carry_r  <= 1'b0;
      sum_r    <= '0;
      busy_r   <= 1'b0;
      ready_r  <= 1'b0;
      neg_r    <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (load) begin
            a_op_r   <= a_bcd;
            b_op_r   <= b_bcd;
            sub_op_r <= sub;
            ready_r  <= 1'b0;
            state_r  <= IDLE;
          end else if (start) begin
            cnt_r <= '0;
            sum_r <= '0;
            neg_r <= 1'b0;
            if (bad_digit_s) begin
              err_r   <= 1'b1;
              ready_r <= 1'b1;
              state_r <= DONE;
            end else begin
              err_r   <= 1'b0;
              ready_r <= 1'b0;
              busy_r  <= 1'b1;
              carry_r <= sub_op_r;
              state_r <= RUN;
              // Packed BCD orders like binary, so a plain compare picks the larger magnitude
              if (sub_op_r && (a_op_r < b_op_r)) begin
                a_sh_r <= b_op_r;
                b_sh_r <= a_op_r;
                neg_r  <= 1'b1;
              end else begin
                a_sh_r <= a_op_r;
                b_sh_r <= b_op_r;
              end
            end
          end else begin
            state_r <= state_r;
          end
        end
        RUN: begin
          sum_r[{cnt_r, 2'b00} +: 4] <= digit_s;
          carry_r <= cout_s;
          a_sh_r  <= a_sh_r >> 4'd4;
          b_sh_r  <= b_sh_r >> 4'd4;
          if (cnt_r == CW'(NDIG - 1)) begin
            sum_r[4*NDIG +: 4] <= sub_op_r ? 4'd0 : {3'd0, cout_s};
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign ready   = ready_r;
  assign sum_bcd = sum_r;
  assign neg     = neg_r;
  assign err     = err_r;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Scoreboard bench: decimal reference model feeds an expectation queue drained on each ready rise.
module tb_bcd_addsub_serial;

  localparam int N = 3;

  typedef struct {
    logic [15:0] sum;
    logic        neg;
    logic        err;
    int          cyc;
    int          busy_n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] a_bcd = '0, b_bcd = '0;
  logic        sub = 1'b0, load = 1'b0, start = 1'b0;
  logic        busy, ready, neg, err;
  logic [15:0] sum_bcd;

  logic [3:0]  a1 = '0, b1 = '0;
  logic        load1 = 1'b0, start1 = 1'b0, busy1, ready1, neg1, err1;
  logic [7:0]  sum1;
  logic [23:0] a6 = '0, b6 = '0;
  logic        load6 = 1'b0, start6 = 1'b0, busy6, ready6, neg6, err6;
  logic [27:0] sum6;

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  logic [11:0] held_a = '0, held_b = '0;
  logic        held_sub = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_addsub_serial #(.NDIG(N)) dut (
    .clk(clk), .rst(rst), .a_bcd(a_bcd), .b_bcd(b_bcd), .sub(sub), .load(load), .start(start),
    .busy(busy), .ready(ready), .sum_bcd(sum_bcd), .neg(neg), .err(err));

  bcd_addsub_serial #(.NDIG(1)) dut1 (
    .clk(clk), .rst(rst), .a_bcd(a1), .b_bcd(b1), .sub(1'b0), .load(load1), .start(start1),
    .busy(busy1), .ready(ready1), .sum_bcd(sum1), .neg(neg1), .err(err1));

  bcd_addsub_serial #(.NDIG(6)) dut6 (
    .clk(clk), .rst(rst), .a_bcd(a6), .b_bcd(b6), .sub(1'b0), .load(load6), .start(start6),
    .busy(busy6), .ready(ready6), .sum_bcd(sum6), .neg(neg6), .err(err6));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int bcd2int(input logic [11:0] v);
    int r = 0;
    for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(input int v);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference: decimal arithmetic on the operand values, independent of any digit pipeline
  function automatic exp_t model(input logic [11:0] a, input logic [11:0] b, input logic s, input int now);
    exp_t e;
    bit   bad = 0;
    int   ia, ib, r;
    for (int i = 0; i < N; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1;
    e.err    = bad;
    e.neg    = 1'b0;
    e.sum    = '0;
    e.busy_n = bad ? 0 : N;
    e.cyc    = now + 1 + (bad ? 0 : N);
    if (!bad) begin
      ia = bcd2int(a);
      ib = bcd2int(b);
      if (!s) r = ia + ib;
      else if (ia < ib) begin r = ib - ia; e.neg = 1'b1; end
      else r = ia - ib;
      e.sum = 16'(int2bcd(r));
    end
    return e;
  endfunction

  task automatic do_load(input logic [11:0] a, input logic [11:0] b, input logic s);
    @(negedge clk);
    a_bcd = a; b_bcd = b; sub = s; load = 1'b1;
    held_a = a; held_b = b; held_sub = s;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(model(held_a, held_b, held_sub, cyc));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 3 * N + 10) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: %0d results outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_op(input logic [11:0] a, input logic [11:0] b, input logic s);
    do_load(a, b, s);
    do_start();
    wait_done("op");
  endtask

  // Monitor: compare every rising ready against the oldest expectation
  initial begin
    logic prev_ready = 1'b0;
    int   busy_n = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) busy_n = 0;
      else if (busy) busy_n++;
      if (ready && !prev_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 32'(ready), 32'(1'b0));
        end else begin
          e = exp_q.pop_front();
          check("sum_bcd", 32'(sum_bcd), 32'(e.sum));
          check("neg", 32'(neg), 32'(e.neg));
          check("err", 32'(err), 32'(e.err));
          check("ready_cycle", 32'(cyc), 32'(e.cyc));
          check("busy_cycles", 32'(busy_n), 32'(e.busy_n));
          check("busy_at_ready", 32'(busy), 32'(1'b0));
        end
        busy_n = 0;
      end
      prev_ready = ready;
    end
  end

  initial begin
    logic [11:0] ra, rb;
    int          k;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_sum", 32'(sum_bcd), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_neg_err", 32'({neg, err}), 32'h0);

    // Held operands are zero after reset
    do_start();
    wait_done("start_after_rst");

    do_op(12'h123, 12'h456, 1'b0);
    do_op(12'h999, 12'h999, 1'b0);
    do_op(12'h007, 12'h015, 1'b0);
    do_op(12'h456, 12'h123, 1'b1);
    do_op(12'h123, 12'h456, 1'b1);
    do_op(12'h500, 12'h500, 1'b1);
    do_op(12'h1A3, 12'h000, 1'b0);
    do_op(12'h111, 12'h222, 1'b0);

    // Restart on the same operands
    do_start();
    wait_done("restart");

    // start and load while running are ignored
    do_load(12'h250, 12'h175, 1'b0);
    do_start();
    @(negedge clk);
    start = 1'b1; load = 1'b1; a_bcd = 12'h888; b_bcd = 12'h777; sub = 1'b1;
    @(negedge clk);
    start = 1'b0; load = 1'b0;
    wait_done("ignore_mid_run");

    // Same-cycle load and start: load wins, ready drops, nothing runs
    @(negedge clk);
    a_bcd = 12'h640; b_bcd = 12'h385; sub = 1'b1; load = 1'b1; start = 1'b1;
    held_a = 12'h640; held_b = 12'h385; held_sub = 1'b1;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    repeat (N + 2) @(negedge clk);
    check("load_wins_ready", 32'(ready), 32'h0);
    check("load_wins_busy", 32'(busy), 32'h0);
    do_start();
    wait_done("after_load_wins");

    // Reset in the second RUN cycle aborts the operation
    do_load(12'h321, 12'h123, 1'b0);
    do_start();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    held_a = '0; held_b = '0; held_sub = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_sum", 32'(sum_bcd), 32'h0);
    check("abort_flags", 32'({busy, ready, neg, err}), 32'h0);
    repeat (N + 2) @(negedge clk);
    check("abort_no_ready", 32'(ready), 32'h0);
    do_start();
    wait_done("after_abort");

    // Randomized operands, occasionally with a non-decimal digit
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 9) == 0) ra[4*$urandom_range(0, N - 1) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 9) == 0) rb[4*$urandom_range(0, N - 1) +: 4] = 4'($urandom_range(10, 15));
      do_op(ra, rb, 1'($urandom_range(0, 1)));
    end

    // NDIG=1: 9+9
    @(negedge clk);
    a1 = 4'h9; b1 = 4'h9; load1 = 1'b1;
    @(negedge clk);
    load1 = 1'b0; start1 = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      start1 = 1'b0;
      k++;
    end while (!ready1 && k < 20);
    check("ndig1_latency", 32'(k), 32'd2);
    check("ndig1_sum", 32'(sum1), 32'h18);

    // NDIG=6: 999999+000001
    @(negedge clk);
    a6 = 24'h999999; b6 = 24'h000001; load6 = 1'b1;
    @(negedge clk);
    load6 = 1'b0; start6 = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      start6 = 1'b0;
      k++;
    end while (!ready6 && k < 30);
    check("ndig6_latency", 32'(k), 32'd7);
    check("ndig6_sum", 32'(sum6), 32'h1000000);
    check("ndig6_flags", 32'({neg6, err6}), 32'h0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
